mem_bank_arbiter: RTL

MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

---
 rtl/mem_bank_pkg.sv | 14 +
 rtl/mem_lane.sv | 39 +++
 rtl/mem_bank_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_bank_pkg.sv
// Shared definitions for the two-requester memory bank arbiter.
// Provides the FSM state encoding and default geometry constants.
package mem_bank_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_LANES  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane.sv
// One 8-bit byte lane of the bank: 2**ADDR_W entries, synchronous write,
// synchronous registered read.
// Ports: clk, rst_n (sync, active-low; clears read register only),
//        we/re strobes, addr, wdata (8 bit), rdata (8 bit, holds between reads).
module mem_lane
  import mem_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  // Storage is never initialised; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register keeps its value until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter giving two requesters access to a byte-lane memory.
// Each access takes IDLE -> ACCESS (gnt pulse) -> RESP (done pulse).
// Ports: clk, rst_n (sync, active-low);
//        per requester p: req_p, we_p, addr_p, be_p, wdata_p in; gnt_p, done_p out;
//        rdata: shared read data, valid with done after a read, held otherwise.
module mem_bank_arbiter
  import mem_bank_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned LANES  = DEF_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_0,
  input  logic                 we_0,
  input  logic [ADDR_W-1:0]    addr_0,
  input  logic [LANES-1:0]     be_0,
  input  logic [8*LANES-1:0]   wdata_0,
  output logic                 gnt_0,
  output logic                 done_0,
  input  logic                 req_1,
  input  logic                 we_1,
  input  logic [ADDR_W-1:0]    addr_1,
  input  logic [LANES-1:0]     be_1,
  input  logic [8*LANES-1:0]   wdata_1,
  output logic                 gnt_1,
  output logic                 done_1,
  output logic [8*LANES-1:0]   rdata
);

  localparam int unsigned DATA_W = 8 * LANES;

  state_t              state, state_nx;
  logic                last_winner;
  logic                pick;
  logic                load;
  logic                mem_go;
  logic                gnt_0_nx, gnt_1_nx, done_0_nx, done_1_nx;

  logic                cmd_sel;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [LANES-1:0]    cmd_be;
  logic [DATA_W-1:0]   cmd_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, arbitration and next output pulses.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    mem_go    = 1'b0;
    gnt_0_nx  = 1'b0;
    gnt_1_nx  = 1'b0;
    done_0_nx = 1'b0;
    done_1_nx = 1'b0;
    // Requester 1 wins when alone, or on a tie when 0 won last time.
    pick      = req_1 && (!req_0 || !last_winner);
    unique case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          state_nx = ACCESS;
          load     = 1'b1;
          gnt_0_nx = !pick;
          gnt_1_nx = pick;
        end
      end
      ACCESS: begin
        state_nx  = RESP;
        mem_go    = 1'b1;
        done_0_nx = !cmd_sel;
        done_1_nx = cmd_sel;
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Output pulses, winner pointer and captured command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_0       <= 1'b0;
      gnt_1       <= 1'b0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      last_winner <= 1'b1;
      cmd_sel     <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_be      <= '0;
      cmd_wdata   <= '0;
    end else begin
      gnt_0  <= gnt_0_nx;
      gnt_1  <= gnt_1_nx;
      done_0 <= done_0_nx;
      done_1 <= done_1_nx;
      if (load) begin
        cmd_sel     <= pick;
        last_winner <= pick;
        cmd_we      <= pick ? we_1    : we_0;
        cmd_addr    <= pick ? addr_1  : addr_0;
        cmd_be      <= pick ? be_1    : be_0;
        cmd_wdata   <= pick ? wdata_1 : wdata_0;
      end
    end
  end

  // One storage lane per byte; memory acts on the ACCESS->RESP edge.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_go && cmd_we && cmd_be[k]),
      .re    (mem_go && !cmd_we),
      .addr  (cmd_addr),
      .wdata (cmd_wdata[8*k +: 8]),
      .rdata (rdata[8*k +: 8])
    );
  end

endmodule
